// File: rtl/simplebus_rx_if.sv
// simplebus receive-side signal bundle: serial line in, valid/ready word out,
// plus status and error pulses. Carries wires only; all state lives in the
// consuming module.
interface simplebus_rx_if #(
   parameter int WIDTH = 8
);
   logic             sb_in;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             parity_err;
   logic             frame_err;
   logic             overrun;

   // Receiver side: samples the line, produces the word and status.
   modport master (
      input  sb_in,
      input  out_ready,
      output out_data,
      output out_valid,
      output busy,
      output parity_err,
      output frame_err,
      output overrun
   );

   // Environment side: drives the line and consumes the word.
   modport slave (
      output sb_in,
      output out_ready,
      input  out_data,
      input  out_valid,
      input  busy,
      input  parity_err,
      input  frame_err,
      input  overrun
   );
endinterface

// File: rtl/simplebus_rx.sv
// simplebus serial receiver. Frame: idle=1, start=0, WIDTH data bits LSB
// first, even parity bit, stop=1. The line is synchronized, the start bit is
// re-checked at its midpoint, every later bit is sampled one bit period after
// the previous sample. A good word goes into a one-entry holding register
// with a valid/ready handshake; bad frames are dropped with a one-cycle pulse.
module simplebus_rx #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst,
   simplebus_rx_if.master bus
);

   localparam int HALF  = BIT_CYCLES / 2;
   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int IDX_W = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   // Even parity: the parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   logic             sync1_r;
   logic             sync2_r;
   logic             s_s;
   state_t           state_r;
   state_t           state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_next_s;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] data_next_s;
   logic             par_r;
   logic             par_next_s;
   logic             perr_s;
   logic             ferr_s;
   logic             dlv_s;
   logic             dlv_r;
   logic             busy_r;
   logic             perr_r;
   logic             ferr_r;
   logic             ovr_r;
   logic [WIDTH-1:0] out_data_r;
   logic             out_valid_r;

   assign s_s = sync2_r;

   // Two-flop synchronizer on the asynchronous serial line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= bus.sb_in;
         sync2_r <= sync1_r;
      end
   end

   // Frame sequencing: next state, bit timing, data capture and frame verdict.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      idx_next_s   = idx_r;
      data_next_s  = data_r;
      par_next_s   = par_r;
      perr_s       = 1'b0;
      ferr_s       = 1'b0;
      dlv_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (s_s == 1'b0) begin
               state_next_s = START;
               cnt_next_s   = '0;
            end else begin
               state_next_s = IDLE;
            end
         end
         START: begin
            if (cnt_r == CNT_HALF_LAST) begin
               cnt_next_s = '0;
               idx_next_s = '0;
               if (s_s == 1'b0) begin
                  state_next_s = DATA;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_r == CNT_BIT_LAST) begin
               // LSB arrives first, so shift right and insert at the top.
               for (int i = 0; i < WIDTH - 1; i++) begin
                  data_next_s[i] = data_r[i+1];
               end
               data_next_s[WIDTH-1] = s_s;
               cnt_next_s = '0;
               idx_next_s = idx_r + IDX_W'(1);
               if (idx_r == IDX_LAST) begin
                  state_next_s = PARITY;
               end else begin
                  state_next_s = DATA;
               end
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_r == CNT_BIT_LAST) begin
               par_next_s   = s_s;
               cnt_next_s   = '0;
               state_next_s = STOP;
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_r == CNT_BIT_LAST) begin
               cnt_next_s = '0;
               if (s_s == 1'b0) begin
                  // Missing stop bit wins over any parity verdict.
                  ferr_s       = 1'b1;
                  state_next_s = BREAK;
               end else if (even_parity(data_r) != par_r) begin
                  perr_s       = 1'b1;
                  state_next_s = IDLE;
               end else begin
                  dlv_s        = 1'b1;
                  state_next_s = IDLE;
               end
            end else begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end
         end
         BREAK: begin
            // A held-low line is not a new start bit; wait for it to recover.
            if (s_s == 1'b1) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = BREAK;
            end
         end
         default: begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
         end
      endcase
   end

   // Frame sequencer state, bit counter and bit index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         idx_r   <= '0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         idx_r   <= idx_next_s;
      end
   end

   // Received data shift register and latched parity bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= '0;
         par_r  <= 1'b0;
      end else begin
         data_r <= data_next_s;
         par_r  <= par_next_s;
      end
   end

   // Registered status: busy, error pulses and the pending-deliver strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         perr_r <= 1'b0;
         ferr_r <= 1'b0;
         dlv_r  <= 1'b0;
      end else begin
         busy_r <= (state_next_s != IDLE);
         perr_r <= perr_s;
         ferr_r <= ferr_s;
         dlv_r  <= dlv_s;
      end
   end

   // One-entry holding register with valid/ready handshake and overrun detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         ovr_r       <= 1'b0;
      end else begin
         ovr_r <= 1'b0;
         if (dlv_r) begin
            // A word leaving in this same cycle frees the slot for the new one.
            if (!out_valid_r || bus.out_ready) begin
               out_data_r  <= data_r;
               out_valid_r <= 1'b1;
            end else begin
               ovr_r <= 1'b1;
            end
         end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign bus.out_data   = out_data_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.busy       = busy_r;
   assign bus.parity_err = perr_r;
   assign bus.frame_err  = ferr_r;
   assign bus.overrun    = ovr_r;

endmodule

// File: tb/tb_simplebus_rx.sv
// Bench for simplebus_rx (WIDTH=8, BIT_CYCLES=4). A serial transmitter task
// builds frames bit by bit; each frame's fate (deliver / parity error / frame
// error) is decided from the frame contents alone and scheduled at the cycle
// the documented latency predicts. A transaction-level holding-slot model then
// checks the outputs every cycle. Directed table entries and hand sequences
// cover the listed corner cases; a randomized run follows.
module tb_simplebus_rx;

   localparam int WIDTH      = 8;
   localparam int BIT_CYCLES = 4;
   localparam int HALF       = BIT_CYCLES / 2;
   // Cycle (relative to driving the start bit) at which an error pulse shows:
   // 1 edge to see the input, then 2 + HALF + (WIDTH+2)*BIT_CYCLES to the
   // stop sample. A delivered word shows one cycle later.
   localparam int LAT_ERR    = 1 + 2 + HALF + (WIDTH + 2) * BIT_CYCLES;

   logic clk = 1'b0;
   logic rst = 1'b1;

   simplebus_rx_if #(.WIDTH(WIDTH)) bus();

   simplebus_rx #(.WIDTH(WIDTH), .BIT_CYCLES(BIT_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      int         kind;   // 0 deliver, 1 parity error, 2 frame error
      logic [7:0] word;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         low_extra;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_perr;
      int         exp_ferr;
   } vec_t;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   ev_t        evq[$];
   logic       mv = 1'b0;
   logic [7:0] md = 8'h00;
   bit         rand_ready = 1'b0;
   int         n_perr, n_ferr, n_ovr;
   bit         busy_seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance one clock and check the outputs against the slot model.
   task automatic tick();
      logic rp, rr, ep, ef, eo, dl;
      ev_t  e;
      rp = bus.out_ready;
      rr = rst;
      @(posedge clk);
      #1;
      cyc++;
      ep = 1'b0; ef = 1'b0; eo = 1'b0; dl = 1'b0;
      if (rr) begin
         mv = 1'b0;
         md = 8'h00;
         evq.delete();
      end else begin
         if (evq.size() > 0 && evq[0].due == cyc) begin
            e = evq.pop_front();
            case (e.kind)
               1: ep = 1'b1;
               2: ef = 1'b1;
               default: begin
                  dl = 1'b1;
                  if (!mv || rp) begin
                     mv = 1'b1;
                     md = e.word;
                  end else begin
                     eo = 1'b1;
                  end
               end
            endcase
         end
         if (!dl && mv && rp) mv = 1'b0;
      end
      check("out_valid", bus.out_valid, mv);
      check("out_data", bus.out_data, md);
      check("parity_err", bus.parity_err, ep);
      check("frame_err", bus.frame_err, ef);
      check("overrun", bus.overrun, eo);
      n_perr += int'(bus.parity_err);
      n_ferr += int'(bus.frame_err);
      n_ovr  += int'(bus.overrun);
      if (bus.busy) busy_seen = 1'b1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 2) == 0);
   endtask

   task automatic send_bit(input logic b);
      bus.sb_in = b;
      repeat (BIT_CYCLES) tick();
   endtask

   // Transmit one frame and schedule its expected outcome.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input int low_extra);
      int kind;
      if (!stop) kind = 2;
      else if ((($countones(data) + int'(par)) % 2) != 0) kind = 1;
      else kind = 0;
      evq.push_back('{due: cyc + LAT_ERR + ((kind == 0) ? 1 : 0), kind: kind, word: data});
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(par);
      send_bit(stop);
      if (!stop) begin
         repeat (low_extra) tick();
         bus.sb_in = 1'b1;
         tick();
      end
      bus.sb_in = 1'b1;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{8'hA5, 1'b0, 1'b1, 0,  1'b1, 8'hA5, 0, 0};
      tbl[1] = '{8'h01, 1'b0, 1'b1, 0,  1'b0, 8'h00, 1, 0};
      tbl[2] = '{8'h3C, 1'b0, 1'b0, 10, 1'b0, 8'h00, 0, 1};
      tbl[3] = '{8'h3C, 1'b0, 1'b1, 0,  1'b1, 8'h3C, 0, 0};
      tbl[4] = '{8'hFF, 1'b0, 1'b1, 0,  1'b1, 8'hFF, 0, 0};
      tbl[5] = '{8'h7F, 1'b0, 1'b1, 0,  1'b0, 8'h00, 1, 0};
      tbl[6] = '{8'h80, 1'b1, 1'b1, 0,  1'b1, 8'h80, 0, 0};

      bus.sb_in     = 1'b1;
      bus.out_ready = 1'b0;
      n_perr = 0; n_ferr = 0; n_ovr = 0; busy_seen = 1'b0;

      // Reset state.
      rst = 1'b1;
      repeat (3) tick();
      check("reset_busy", bus.busy, 1'b0);
      rst = 1'b0;
      repeat (2) tick();

      // Table of single frames.
      for (int i = 0; i < 7; i++) begin
         drain();
         n_perr = 0; n_ferr = 0; n_ovr = 0;
         send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].low_extra);
         if (!tbl[i].stop) check("busy_while_low", bus.busy, 1'b1);
         repeat (8) tick();
         check("busy_after_frame", bus.busy, 1'b0);
         check("perr_count", n_perr, tbl[i].exp_perr);
         check("ferr_count", n_ferr, tbl[i].exp_ferr);
         check("ovr_count", n_ovr, 0);
         check("tbl_valid", bus.out_valid, tbl[i].exp_valid);
         if (tbl[i].exp_valid) begin
            check("tbl_data", bus.out_data, tbl[i].exp_data);
            repeat (4) tick();
            check("held_valid", bus.out_valid, 1'b1);
            check("held_data", bus.out_data, tbl[i].exp_data);
            bus.out_ready = 1'b1;
            tick();
            check("accept_clears", bus.out_valid, 1'b0);
            bus.out_ready = 1'b0;
         end
      end

      // Back-to-back frames with the consumer stalled: second one overruns.
      drain();
      n_perr = 0; n_ferr = 0; n_ovr = 0;
      send_frame(8'h11, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 0);
      repeat (8) tick();
      check("b2b_valid", bus.out_valid, 1'b1);
      check("b2b_data", bus.out_data, 8'h11);
      check("b2b_ovr_count", n_ovr, 1);

      // One-cycle glitch on the line: start rejected, no pulse.
      drain();
      n_perr = 0; n_ferr = 0; n_ovr = 0; busy_seen = 1'b0;
      bus.sb_in = 1'b0;
      tick();
      bus.sb_in = 1'b1;
      repeat (8) tick();
      check("glitch_busy_seen", busy_seen, 1'b1);
      check("glitch_busy_end", bus.busy, 1'b0);
      check("glitch_valid", bus.out_valid, 1'b0);
      check("glitch_pulses", n_perr + n_ferr + n_ovr, 0);

      // Reset in the middle of data bit 4, then a clean frame.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus.sb_in = 1'b0;
      tick();
      tick();
      check("busy_mid_frame", bus.busy, 1'b1);
      rst = 1'b1;
      bus.sb_in = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_abort_busy", bus.busy, 1'b0);
      check("rst_abort_valid", bus.out_valid, 1'b0);
      n_perr = 0; n_ferr = 0; n_ovr = 0;
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      repeat (8) tick();
      check("after_rst_valid", bus.out_valid, 1'b1);
      check("after_rst_data", bus.out_data, 8'h5A);
      check("after_rst_pulses", n_perr + n_ferr + n_ovr, 0);
      drain();

      // Randomized frames, gaps and consumer back-pressure.
      rand_ready = 1'b1;
      for (int f = 0; f < 30; f++) begin
         logic [7:0] d;
         int         r;
         d = 8'($urandom());
         r = $urandom_range(0, 5);
         send_frame(d, logic'(($countones(d) % 2) != 0) ^ (r == 0), (r != 1),
                    $urandom_range(0, 5));
         repeat ($urandom_range(0, 5)) tick();
      end
      rand_ready = 1'b0;
      bus.out_ready = 1'b1;
      repeat (60) tick();
      check("events_drained", evq.size(), 0);
      check("final_busy", bus.busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
